// File: rtl/matmul_pkg.sv
// Shared types and defaults for the 8x8 matrix-vector sequencer.
package matmul_pkg;

    localparam int unsigned DIM_DEFAULT     = 8;
    localparam int unsigned MAC_LAT_DEFAULT = 8;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_LOAD_W,
        ST_WAIT_CMD,
        ST_LOAD_X,
        ST_COMPUTE,
        ST_DRAIN
    } ctrl_state_t;

    typedef enum logic [1:0] {
        BANK_FREE,
        BANK_BUSY,
        BANK_FULL
    } bank_state_t;

    // Tag that travels with each issued operand through the MAC pipeline.
    typedef struct packed {
        logic valid;
        logic bank;
        logic last;
    } acc_tag_t;

endpackage

// File: rtl/acc_delay_line.sv
// Fixed-latency shadow of the MAC pipeline: each issue tag re-emerges
// MAC_LAT cycles later to drive the accumulate enable.
module acc_delay_line
    import matmul_pkg::*;
#(
    parameter int unsigned MAC_LAT = MAC_LAT_DEFAULT
) (
    input  logic     clk,
    input  logic     rst_n,
    input  acc_tag_t tag_in,
    output acc_tag_t tag_out
);

    acc_tag_t stage_q [MAC_LAT];
    acc_tag_t stage_d [MAC_LAT];

    always_comb begin
        stage_d[0] = tag_in;
        for (int unsigned i = 1; i < MAC_LAT; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < MAC_LAT; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < MAC_LAT; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign tag_out = stage_q[MAC_LAT-1];

endmodule

// File: rtl/matvec_pipe_ctrl.sv
// Sequencer for the matrix-vector datapath: loads W/X memories, issues MAC
// operand reads row-major and ping-pongs results through two accumulator banks.
module matvec_pipe_ctrl
    import matmul_pkg::*;
#(
    parameter int unsigned DIM     = DIM_DEFAULT,
    parameter int unsigned MAC_LAT = MAC_LAT_DEFAULT,
    parameter int unsigned AW      = $clog2(DIM*DIM),
    parameter int unsigned XW      = $clog2(DIM)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          input_valid,
    output logic          input_ready,
    input  logic          new_matrix,
    output logic [AW-1:0] addr_w,
    output logic          wr_en_w,
    output logic [XW-1:0] addr_x,
    output logic          wr_en_x,
    output logic          issue_valid,
    output logic [1:0]    en_acc,
    output logic [1:0]    clear_acc,
    output logic          output_valid,
    input  logic          output_ready,
    output logic          out_sel,
    output logic          busy
);

    localparam logic [AW-1:0] W_LAST   = AW'(DIM*DIM-1);
    localparam logic [AW-1:0] X_LAST   = AW'(DIM-1);
    localparam logic [XW-1:0] COL_LAST = XW'(DIM-1);
    localparam logic [XW:0]   HS_LAST  = (XW+1)'(DIM-1);

    ctrl_state_t   state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [XW:0]   hs_cnt_q, hs_cnt_d;
    bank_state_t   bank_q [2];
    bank_state_t   bank_d [2];
    logic          out_sel_q, out_sel_d;
    logic          input_ready_q, input_ready_d;
    logic          busy_q, busy_d;

    logic          accept;
    logic          issue;
    logic          row_bank;
    logic          hs;
    logic [XW-1:0] col;
    acc_tag_t      issue_tag;
    acc_tag_t      acc_tag;

    // One counter serves as load index and as row-major issue index (row = upper bits).
    assign col       = cnt_q[XW-1:0];
    assign row_bank  = cnt_q[XW];
    assign accept    = input_valid && input_ready_q;
    assign issue     = (state_q == ST_COMPUTE) &&
                       ((col != '0) || (bank_q[row_bank] == BANK_FREE));
    assign hs        = (bank_q[out_sel_q] == BANK_FULL) && output_ready;
    assign issue_tag = '{valid: issue, bank: row_bank, last: (col == COL_LAST)};

    acc_delay_line #(
        .MAC_LAT (MAC_LAT)
    ) u_delay (
        .clk     (clk),
        .rst_n   (rst_n),
        .tag_in  (issue_tag),
        .tag_out (acc_tag)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hs_cnt_d  = hs_cnt_q;
        bank_d    = bank_q;
        out_sel_d = out_sel_q;

        case (state_q)
            ST_INIT: state_d = ST_LOAD_W;
            ST_LOAD_W: begin
                if (accept) begin
                    if (cnt_q == W_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_LOAD_X;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_LOAD_X: begin
                if (accept) begin
                    if (cnt_q == X_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_COMPUTE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_WAIT_CMD: begin
                if (accept) begin
                    cnt_d   = AW'(1);
                    state_d = new_matrix ? ST_LOAD_W : ST_LOAD_X;
                end
            end
            ST_COMPUTE: begin
                if (issue) begin
                    if (cnt_q == W_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (hs && (hs_cnt_q == HS_LAST)) begin
                    state_d = ST_WAIT_CMD;
                end
            end
            default: state_d = ST_INIT;
        endcase

        // The three bank transitions never collide: each requires a distinct source state.
        if (issue && (col == '0)) begin
            bank_d[row_bank] = BANK_BUSY;
        end
        if (acc_tag.valid && acc_tag.last) begin
            bank_d[acc_tag.bank] = BANK_FULL;
        end
        if (hs) begin
            bank_d[out_sel_q] = BANK_FREE;
            out_sel_d         = ~out_sel_q;
        end

        if ((state_q == ST_DRAIN) && (state_d == ST_WAIT_CMD)) begin
            hs_cnt_d = '0;
        end else if (hs) begin
            hs_cnt_d = hs_cnt_q + 1'b1;
        end

        input_ready_d = (state_d == ST_LOAD_W) || (state_d == ST_LOAD_X) ||
                        (state_d == ST_WAIT_CMD);
        busy_d        = (state_d != ST_WAIT_CMD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_INIT;
            cnt_q         <= '0;
            hs_cnt_q      <= '0;
            bank_q[0]     <= BANK_FREE;
            bank_q[1]     <= BANK_FREE;
            out_sel_q     <= 1'b0;
            input_ready_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            hs_cnt_q      <= hs_cnt_d;
            bank_q[0]     <= bank_d[0];
            bank_q[1]     <= bank_d[1];
            out_sel_q     <= out_sel_d;
            input_ready_q <= input_ready_d;
            busy_q        <= busy_d;
        end
    end

    assign input_ready  = input_ready_q;
    assign busy         = busy_q;
    assign addr_w       = cnt_q;
    assign addr_x       = col;
    assign wr_en_w      = accept && ((state_q == ST_LOAD_W) ||
                                     ((state_q == ST_WAIT_CMD) && new_matrix));
    assign wr_en_x      = accept && ((state_q == ST_LOAD_X) ||
                                     ((state_q == ST_WAIT_CMD) && !new_matrix));
    assign issue_valid  = issue;
    assign en_acc       = acc_tag.valid ? (acc_tag.bank ? 2'b10 : 2'b01) : 2'b00;
    assign clear_acc    = (state_q == ST_INIT) ? 2'b11 :
                          (hs ? (out_sel_q ? 2'b10 : 2'b01) : 2'b00);
    assign output_valid = (bank_q[out_sel_q] == BANK_FULL);
    assign out_sel      = out_sel_q;

endmodule

// File: tb/tb_matvec_pipe_ctrl.sv
// Self-checking bench: random stimulus against a row-schedule reference model.
module tb_matvec_pipe_ctrl;

    localparam int DIM     = 8;
    localparam int MAC_LAT = 8;
    localparam int AW      = 6;
    localparam int XW      = 3;
    localparam int MAXT    = 600;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          input_valid;
    logic          input_ready;
    logic          new_matrix;
    logic [AW-1:0] addr_w;
    logic          wr_en_w;
    logic [XW-1:0] addr_x;
    logic          wr_en_x;
    logic          issue_valid;
    logic [1:0]    en_acc;
    logic [1:0]    clear_acc;
    logic          output_valid;
    logic          output_ready;
    logic          out_sel;
    logic          busy;

    always #5 clk = ~clk;

    matvec_pipe_ctrl #(
        .DIM     (DIM),
        .MAC_LAT (MAC_LAT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .input_valid  (input_valid),
        .input_ready  (input_ready),
        .new_matrix   (new_matrix),
        .addr_w       (addr_w),
        .wr_en_w      (wr_en_w),
        .addr_x       (addr_x),
        .wr_en_x      (wr_en_x),
        .issue_valid  (issue_valid),
        .en_acc       (en_acc),
        .clear_acc    (clear_acc),
        .output_valid (output_valid),
        .output_ready (output_ready),
        .out_sel      (out_sel),
        .busy         (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Row schedule of one compute pass: start, bank-full and handshake cycles.
    int s_row [DIM];
    int f_row [DIM];
    int h_row [DIM];
    bit ready_pat [MAXT];
    int hs_obs [$];
    int rdy_obs;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int row_at(input int u);
        for (int r = 0; r < DIM; r++) begin
            if (u >= s_row[r] && u < s_row[r] + DIM) return r;
        end
        return -1;
    endfunction

    function automatic void build_schedule();
        int t;
        for (int r = 0; r < DIM; r++) begin
            if (r == 0) s_row[r] = 0;
            else if (r < 2) s_row[r] = s_row[r-1] + DIM;
            else s_row[r] = (s_row[r-1] + DIM > h_row[r-2] + 1) ? s_row[r-1] + DIM : h_row[r-2] + 1;
            // last element issued at s+DIM-1, accumulated MAC_LAT later, full one cycle after
            f_row[r] = s_row[r] + DIM + MAC_LAT;
            t = f_row[r];
            if (r > 0 && h_row[r-1] + 1 > t) t = h_row[r-1] + 1;
            while (t < MAXT - 1 && !ready_pat[t]) t++;
            h_row[r] = t;
        end
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_clear_acc"}, clear_acc, 2'b11);
        check_eq({tag, "_in_ready"}, input_ready, 0);
        check_eq({tag, "_addr_w"}, addr_w, 0);
        check_eq({tag, "_addr_x"}, addr_x, 0);
        check_eq({tag, "_wr_en"}, {wr_en_w, wr_en_x}, 0);
        check_eq({tag, "_issue"}, issue_valid, 0);
        check_eq({tag, "_en_acc"}, en_acc, 0);
        check_eq({tag, "_out_valid"}, output_valid, 0);
        check_eq({tag, "_out_sel"}, out_sel, 0);
        check_eq({tag, "_busy"}, busy, 0);
    endtask

    task automatic reset_and_release();
        rst_n        = 1'b0;
        input_valid  = 1'b0;
        output_ready = 1'($urandom_range(0, 1));
        for (int i = 0; i < MAC_LAT + 4; i++) begin
            @(negedge clk);
            check_reset_outputs("rst");
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("init_clear_acc", clear_acc, 2'b11);
        check_eq("init_in_ready", input_ready, 0);
        check_eq("init_en_acc", en_acc, 0);
        @(posedge clk); #1;
    endtask

    task automatic load_stream(input bit is_w, input bit from_wait, input int gap_mode);
        int n;
        int i;
        int guard;
        bit v;
        n = is_w ? DIM * DIM : DIM;
        i = 0;
        guard = 0;
        while (i < n && guard < 4 * n + 8) begin
            case (gap_mode)
                0:       v = 1'b1;
                1:       v = (guard % 2 == 0);
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            input_valid  = v;
            new_matrix   = (from_wait && i == 0) ? is_w : 1'($urandom_range(0, 1));
            output_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_eq("ld_in_ready", input_ready, 1);
            check_eq("ld_busy", busy, !(from_wait && i == 0));
            check_eq("ld_wr_en_w", wr_en_w, v && is_w);
            check_eq("ld_wr_en_x", wr_en_x, v && !is_w);
            if (v) begin
                if (is_w) check_eq("ld_addr_w", addr_w, i);
                else      check_eq("ld_addr_x", addr_x, i);
            end
            check_eq("ld_issue", issue_valid, 0);
            check_eq("ld_en_acc", en_acc, 0);
            check_eq("ld_out_valid", output_valid, 0);
            check_eq("ld_clear_acc", clear_acc, 0);
            @(posedge clk); #1;
            if (v) i++;
            guard++;
        end
        input_valid = 1'b0;
    endtask

    // mode 0: ready always; 1: ready from cycle 40; 2: mostly ready; 3: rarely ready.
    task automatic run_compute(input int mode, input int abort_at);
        int t_end;
        int r;
        int q;
        int k;
        for (int t = 0; t < MAXT; t++) begin
            case (mode)
                0:       ready_pat[t] = 1'b1;
                1:       ready_pat[t] = (t >= 40);
                2:       ready_pat[t] = (t >= 400) || ($urandom_range(0, 3) != 0);
                default: ready_pat[t] = (t >= 400) || ($urandom_range(0, 3) == 0);
            endcase
        end
        build_schedule();
        hs_obs.delete();
        rdy_obs = -1;
        t_end = h_row[DIM-1] + 1;
        for (int t = 0; t <= t_end; t++) begin
            output_ready = ready_pat[t];
            input_valid  = (t == t_end) ? 1'b0 : 1'($urandom_range(0, 1));
            new_matrix   = 1'($urandom_range(0, 1));
            if (t == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_reset_outputs("abort");
                return;
            end
            @(negedge clk);
            r = row_at(t);
            check_eq("issue_valid", issue_valid, r >= 0);
            if (r >= 0) begin
                check_eq("issue_addr_w", addr_w, r * DIM + (t - s_row[r]));
                check_eq("issue_addr_x", addr_x, t - s_row[r]);
            end
            q = row_at(t - MAC_LAT);
            check_eq("en_acc", en_acc, (q >= 0) ? ((q % 2 == 1) ? 2 : 1) : 0);
            k = 0;
            while (k < DIM && h_row[k] < t) k++;
            check_eq("output_valid", output_valid, (k < DIM) && (f_row[k] <= t));
            check_eq("out_sel", out_sel, k % 2);
            check_eq("clear_acc", clear_acc,
                     (k < DIM && h_row[k] == t) ? ((k % 2 == 1) ? 2 : 1) : 0);
            check_eq("cmp_in_ready", input_ready, t == t_end);
            check_eq("cmp_busy", busy, t != t_end);
            check_eq("cmp_wr_en", {wr_en_w, wr_en_x}, 0);
            if (output_valid && output_ready) hs_obs.push_back(t);
            if (input_ready && rdy_obs < 0) rdy_obs = t;
            @(posedge clk); #1;
        end
        input_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs_ref [DIM];
        hs_ref = '{16, 24, 33, 41, 50, 58, 67, 75};
        rst_n        = 1'b0;
        input_valid  = 1'b0;
        new_matrix   = 1'b0;
        output_ready = 1'b0;

        reset_and_release();
        load_stream(1'b1, 1'b0, 0);
        load_stream(1'b0, 1'b0, 0);
        run_compute(0, -1);
        for (int i = 0; i < DIM; i++) begin
            check_eq("hs_cycle", (hs_obs.size() > i) ? hs_obs[i] : -1, hs_ref[i]);
        end
        check_eq("wait_cmd_cycle", rdy_obs, 76);

        // new vector reusing the retained weights, consumer stalled until cycle 40
        load_stream(1'b0, 1'b1, 0);
        run_compute(1, -1);
        check_eq("stall_first_hs", (hs_obs.size() > 0) ? hs_obs[0] : -1, 40);

        for (int trial = 0; trial < 3; trial++) begin
            load_stream(1'b0, 1'b1, 2);
            run_compute(2 + (trial % 2), -1);
        end

        // new matrix from WAIT_CMD with a beat offered every other cycle
        load_stream(1'b1, 1'b1, 1);
        load_stream(1'b0, 1'b0, 2);
        run_compute(2, -1);

        // reset mid-compute, then full reload is required
        load_stream(1'b0, 1'b1, 0);
        run_compute(0, 20);
        reset_and_release();
        load_stream(1'b1, 1'b0, 1);
        load_stream(1'b0, 1'b0, 0);
        run_compute(0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/matvec_pipe_ctrl.md
# matvec_pipe_ctrl

Pipelined sequencer for the 8x8 matrix-vector multiplier datapath. It loads the weight and vector memories from the input stream. It then issues one multiply-accumulate operand read per cycle into a MAC pipeline of fixed latency, and steers results into two ping-pong accumulator banks. Results drain through a valid/ready output port, so row r+1 accumulates while row r waits for the consumer.

## Interface
- DIM, 8: matrix dimension; power of two, ≥2.
- MAC_LAT, 8: cycles from an operand-read issue to its accumulate-enable; ≥1.
- AW, $clog2(DIM*DIM): weight address width (derived).
- XW, $clog2(DIM): vector address width (derived).

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- input_valid  in  1  input beat valid.
- input_ready  out  1  controller accepts input beat.
- new_matrix  in  1  in WAIT_CMD: 1 = stream is a weight matrix, 0 = stream is a vector.
- addr_w  out  AW  weight memory address (write or read).
- wr_en_w  out  1  weight memory write strobe.
- addr_x  out  XW  vector memory address (write or read).
- wr_en_x  out  1  vector memory write strobe.
- issue_valid  out  1  operand read issued this cycle.
- en_acc  out  2  one-hot accumulate enable per bank.
- clear_acc  out  2  per-bank accumulator clear.
- output_valid  out  1  result of bank out_sel available.
- output_ready  in  1  consumer accepts result.
- out_sel  out  1  bank presented on output.
- busy  out  1  state is not WAIT_CMD.

## Operation
- States: INIT, LOAD_W, WAIT_CMD, LOAD_X, COMPUTE, DRAIN.
- INIT: clear_acc=2'b11. Next state is LOAD_W.
- LOAD_W: input_ready=1. Each accepted beat writes addr_w=load count and increments the count. After beat DIM*DIM-1 the count wraps to 0 and the next state is LOAD_X.
- LOAD_X: same scheme on the x memory with DIM beats. After the last beat the next state is COMPUTE.
- WAIT_CMD: input_ready=1. An accepted beat with new_matrix=1 is written as W[0] and the next state is LOAD_W with count 1. An accepted beat with new_matrix=0 is written as X[0] and the next state is LOAD_X with count 1. new_matrix is ignored in all other states.
- COMPUTE: issue order is row-major, with addr_w=row*DIM+col and addr_x=col. Row r targets bank r[0].
  - A row's first issue waits until its bank is FREE; that issue sets the bank to BUSY.
  - Within a row, issues are back-to-back with no stall.
  - After the last issue of row DIM-1 the next state is DRAIN.
- Bank states: FREE → BUSY (first issue) → FULL (cycle after the en_acc of the row's last element) → FREE (cycle after the output handshake).
- Output handshake: output_valid=1 when bank[out_sel] is FULL.
  - On output_valid&&output_ready: clear_acc[out_sel]=1 that cycle and out_sel toggles.
- DRAIN: when all DIM results have been handshaken, the next state is WAIT_CMD.
- input_ready=0 in COMPUTE and DRAIN.
- A weight reload is never forced; the weight memory is retained across vectors.

## Timing
- en_acc[b] is asserted exactly MAC_LAT cycles after the issue cycle that targeted bank b. The pipeline is never stalled once an operand is issued.
- First issue occurs in the cycle after the final X beat is accepted; call that cycle 0.
- With output_ready held at 1, DIM=8, MAC_LAT=8:
  - Row start cycles: 0, 8, 17, 25, 34, 42, 51, 59.
  - Output handshakes: 16, 24, 33, 41, 50, 58, 67, 75.
  - WAIT_CMD (input_ready=1) from cycle 76.
- output_valid is held until output_ready. Result data is stable while output_valid=1 because the bank is not written again until it is FREE.
- Simultaneous events in one cycle:
  - Handshake on bank b and last en_acc on the other bank: both take effect.
  - A free of bank b does not permit an issue to b in the same cycle.
- Reset values: state=INIT, all counters=0, banks FREE, out_sel=0, delay line empty.
  - Outputs while rst_n=0: clear_acc=2'b11, everything else 0.
- Reset mid-operation:
  - In-flight en_acc pulses are discarded.
  - Any pending output is dropped.
  - The controller returns to INIT, then LOAD_W; the weights must be reloaded.

## Structure
- Package matmul_pkg holds:
  - ctrl_state_t enum (6 states).
  - bank_state_t enum (FREE/BUSY/FULL).
  - DIM_DEFAULT and MAC_LAT_DEFAULT.
- Sub-module acc_delay_line: a MAC_LAT-deep shift register carrying {valid, bank, last}, asynchronously cleared by rst_n. Its output drives en_acc and the BUSY→FULL transition.

## Test plan
- Reset then 64 W beats and 8 X beats with input_valid=1 and output_ready=1:
  - addr_w runs 0..63 and addr_x runs 0..7 with the write strobes set.
  - Output handshakes occur at cycles 16, 24, 33, 41, 50, 58, 67, 75, each with clear_acc one-hot matching out_sel.
  - input_ready=1 at cycle 76.
- output_ready=0 until cycle 40 after the first issue:
  - Issue stalls at row 2 with both banks FULL.
  - No en_acc pulse is ever lost.
  - The first handshake occurs at cycle 40 with out_sel=0.
- In WAIT_CMD, an X beat with new_matrix=0:
  - Enters LOAD_X with wr_en_x and addr_x=0.
  - The existing weights are reused; the same 8 results are produced for the same X.
- Deassert input_valid every other cycle during LOAD_W:
  - The count advances only on accepted beats.
  - The transition to LOAD_X occurs after exactly 64 accepted beats.
- Assert rst_n=0 at cycle 20 of COMPUTE:
  - All outputs drop immediately to their reset values and no later en_acc appears.
  - After release the controller passes INIT then LOAD_W and requires 64 W beats.
